// File: rtl/mux_scan_ctrl_pkg.sv
// ============================================================================
// Module   : mux_scan_ctrl_pkg
// Brief    : Shared types and constants for the 4:1 mux scan controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_scan_ctrl_pkg;

    localparam int c_DEFAULT_DWELL = 4;
    localparam int c_NUM_CH        = 4;
    localparam int c_SEL_W         = $clog2(c_NUM_CH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/dwell_counter.sv
// ============================================================================
// Module   : dwell_counter
// Brief    : Per-channel dwell counter with clear, enable and terminal count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dwell_counter #(
    parameter int WIDTH    = 2,
    parameter int TERMINAL = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [WIDTH-1:0] c_TERM = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign tc = (r_count == c_TERM);

endmodule

`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
// ============================================================================
// Module   : mux_scan_ctrl
// Brief    : Scans a 4:1 mux, dwelling DWELL cycles per channel, and publishes
//            the captured 4-bit vector once all channels have been sampled.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int DWELL = c_DEFAULT_DWELL
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                continuous,
    input  logic                mux_y,
    output logic [c_SEL_W-1:0]  select,
    output logic [c_NUM_CH-1:0] sample_vec,
    output logic                vec_valid,
    output logic                busy
);

    localparam int                 c_CNT_W   = $clog2(DWELL);
    localparam logic [c_SEL_W-1:0] c_LAST_CH = c_SEL_W'(c_NUM_CH - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_SEL_W-1:0]  r_select;
    logic [c_SEL_W-1:0]  w_select_nxt;
    logic [c_NUM_CH-1:0] r_shadow;
    logic [c_NUM_CH-1:0] w_shadow_nxt;
    logic [c_NUM_CH-1:0] r_sample_vec;
    logic [c_NUM_CH-1:0] w_sample_vec_nxt;
    logic                r_vec_valid;
    logic                w_vec_valid_nxt;
    logic                w_cnt_clear;
    logic                w_cnt_en;
    logic                w_cnt_tc;

    // SETTLE lasts DWELL-1 cycles, SAMPLE adds one more: DWELL cycles per channel
    dwell_counter #(
        .WIDTH    (c_CNT_W),
        .TERMINAL (DWELL - 2)
    ) u_dwell_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_cnt_clear),
        .enable (w_cnt_en),
        .tc     (w_cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_select     <= '0;
            r_shadow     <= '0;
            r_sample_vec <= '0;
            r_vec_valid  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_select     <= w_select_nxt;
            r_shadow     <= w_shadow_nxt;
            r_sample_vec <= w_sample_vec_nxt;
            r_vec_valid  <= w_vec_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_select_nxt     = r_select;
        w_shadow_nxt     = r_shadow;
        w_sample_vec_nxt = r_sample_vec;
        w_vec_valid_nxt  = 1'b0;
        w_cnt_clear      = 1'b1;
        w_cnt_en         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_select_nxt = '0;
                if (start) begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                w_cnt_clear = 1'b0;
                w_cnt_en    = 1'b1;
                if (w_cnt_tc) begin
                    w_state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                w_shadow_nxt[r_select] = mux_y;
                // Last channel wraps select to 0 so channel 3 is held only DWELL cycles
                w_select_nxt = r_select + c_SEL_W'(1);
                w_state_nxt  = (r_select == c_LAST_CH) ? ST_DONE : ST_SETTLE;
            end
            ST_DONE: begin
                w_sample_vec_nxt = r_shadow;
                w_vec_valid_nxt  = 1'b1;
                w_select_nxt     = '0;
                w_state_nxt      = continuous ? ST_SETTLE : ST_IDLE;
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_select_nxt = '0;
            end
        endcase
    end

    assign select     = r_select;
    assign sample_vec = r_sample_vec;
    assign vec_valid  = r_vec_valid;
    assign busy       = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
// ============================================================================
// Module   : tb_mux_scan_ctrl
// Brief    : Scoreboard bench for mux_scan_ctrl with DWELL=4 and DWELL=2 instances.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start4, cont4, mux_y4, vec_valid4, busy4;
    logic [1:0] select4;
    logic [3:0] sample_vec4, ch_in4;
    logic       start2, cont2, mux_y2, vec_valid2, busy2;
    logic [1:0] select2;
    logic [3:0] sample_vec2, ch_in2;

    int edge_cnt = 0;
    int total    = 0;
    int bad      = 0;

    typedef struct {
        logic [3:0] vec;
        int         at;
    } exp_t;

    exp_t q4[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Behavioural 4:1 mux: channel i drives ch_in[i]
    assign mux_y4 = ch_in4[select4];
    assign mux_y2 = ch_in2[select2];

    mux_scan_ctrl #(.DWELL(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start4),
        .continuous (cont4),
        .mux_y      (mux_y4),
        .select     (select4),
        .sample_vec (sample_vec4),
        .vec_valid  (vec_valid4),
        .busy       (busy4)
    );

    mux_scan_ctrl #(.DWELL(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .start      (start2),
        .continuous (cont2),
        .mux_y      (mux_y2),
        .select     (select2),
        .sample_vec (sample_vec2),
        .vec_valid  (vec_valid2),
        .busy       (busy2)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q4.size() != 0 && edge_cnt > q4[0].at) begin
            e = q4.pop_front();
            check("dwell4 missing vec_valid", 0, 1);
        end
        if (vec_valid4) begin
            if (q4.size() == 0) begin
                check("dwell4 unexpected vec_valid", 1, 0);
            end else begin
                e = q4.pop_front();
                check("dwell4 sample_vec", int'(sample_vec4), int'(e.vec));
                check("dwell4 vec_valid edge", edge_cnt, e.at);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (q2.size() != 0 && edge_cnt > q2[0].at) begin
            e = q2.pop_front();
            check("dwell2 missing vec_valid", 0, 1);
        end
        if (vec_valid2) begin
            if (q2.size() == 0) begin
                check("dwell2 unexpected vec_valid", 1, 0);
            end else begin
                e = q2.pop_front();
                check("dwell2 sample_vec", int'(sample_vec2), int'(e.vec));
                check("dwell2 vec_valid edge", edge_cnt, e.at);
            end
        end
    end

    // Returns the edge count of the edge that sampled start (j=0 negedge)
    task automatic start_scan4(output int k);
        @(negedge clk) start4 = 1'b1;
        @(negedge clk) start4 = 1'b0;
        k = edge_cnt;
    endtask

    task automatic start_scan2(output int k);
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        k = edge_cnt;
    endtask

    initial begin
        int k;
        rst    = 1'b1;
        start4 = 1'b0; cont4 = 1'b0; ch_in4 = 4'b0000;
        start2 = 1'b0; cont2 = 1'b0; ch_in2 = 4'b0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset select",     int'(select4),     0);
        check("reset busy",       int'(busy4),       0);
        check("reset sample_vec", int'(sample_vec4), 0);
        check("reset vec_valid",  int'(vec_valid4),  0);
        check("reset busy dwell2", int'(busy2),      0);

        // Single scan, a..d = 1,0,1,1, with select trace
        ch_in4 = 4'b1101;
        start_scan4(k);
        q4.push_back('{vec: 4'b1101, at: k + 17});
        for (int j = 0; j < 19; j++) begin
            check("select trace", int'(select4), (j < 16) ? j / 4 : 0);
            if (j == 16) check("busy in DONE", int'(busy4), 1);
            if (j == 18) check("busy after scan", int'(busy4), 0);
            @(negedge clk);
        end

        // Start pulsed again mid-scan must be ignored
        ch_in4 = 4'b0110;
        start_scan4(k);
        q4.push_back('{vec: 4'b0110, at: k + 17});
        for (int j = 0; j < 22; j++) begin
            if (j == 5) start4 = 1'b1;
            if (j == 6) start4 = 1'b0;
            if (j == 10) check("sample_vec held mid-scan", int'(sample_vec4), 4'b1101);
            @(negedge clk);
        end
        check("busy after ignored start", int'(busy4), 0);
        check("sample_vec holds", int'(sample_vec4), 4'b0110);

        // Reset mid-scan aborts silently
        ch_in4 = 4'b1111;
        start_scan4(k);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort select",     int'(select4),     0);
        check("abort busy",       int'(busy4),       0);
        check("abort sample_vec", int'(sample_vec4), 0);
        check("abort vec_valid",  int'(vec_valid4),  0);
        repeat (20) @(negedge clk);
        ch_in4 = 4'b1001;
        start_scan4(k);
        q4.push_back('{vec: 4'b1001, at: k + 17});
        repeat (20) @(negedge clk);

        // Continuous mode, inputs changed during first DONE
        ch_in4 = 4'b0101;
        cont4  = 1'b1;
        start_scan4(k);
        q4.push_back('{vec: 4'b0101, at: k + 17});
        q4.push_back('{vec: 4'b1010, at: k + 34});
        for (int j = 0; j < 37; j++) begin
            if (j == 16) ch_in4 = 4'b1010;
            if (j == 17) cont4 = 1'b0;
            if (j == 25) check("busy continuous rescan", int'(busy4), 1);
            if (j == 30) check("no partial vector", int'(sample_vec4), 4'b0101);
            if (j == 36) check("busy after continuous", int'(busy4), 0);
            @(negedge clk);
        end

        // DWELL=2 instance
        ch_in2 = 4'b0011;
        start_scan2(k);
        q2.push_back('{vec: 4'b0011, at: k + 9});
        for (int j = 0; j < 11; j++) begin
            check("dwell2 select trace", int'(select2), (j < 8) ? j / 2 : 0);
            @(negedge clk);
        end
        check("dwell2 busy after scan", int'(busy2), 0);

        repeat (3) @(negedge clk);
        check("dwell4 scoreboard drained", q4.size(), 0);
        check("dwell2 scoreboard drained", q2.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter: DWELL, default 4, cycles spent on each mux channel (legal range 2..255).
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  begin one scan of channels 0..3; sampled only in IDLE.
REQ-005 Port: continuous  input  1  when 1, restart scan automatically after each completed vector.
REQ-006 Port: mux_y  input  1  output of the downstream 4:1 mux being scanned.
REQ-007 Port: select  output  2  channel select driven to the 4:1 mux.
REQ-008 Port: sample_vec  output  4  last completed scan; bit i = mux_y captured with select=i.
REQ-009 Port: vec_valid  output  1  one-cycle pulse when sample_vec has just been updated.
REQ-010 Port: busy  output  1  high in every state except IDLE.

Function
REQ-011 FSM states SHALL be IDLE, SETTLE, SAMPLE, DONE; state, select, counter, shadow and outputs all registered.
REQ-012 IDLE: select=00, busy=0; start=1 -> SETTLE with select=00, dwell counter=0.
REQ-013 SETTLE: counter increments each cycle; when counter reaches DWELL-2 -> SAMPLE (SETTLE lasts DWELL-1 cycles).
REQ-014 SAMPLE: shadow[select] <= mux_y; if select==3 -> DONE, else select <= select+1, counter <= 0, -> SETTLE.
REQ-015 Each channel SHALL therefore be held on select for exactly DWELL cycles; select never changes outside SAMPLE->SETTLE or DONE/reset.
REQ-016 DONE (one cycle): sample_vec <= shadow, with vec_valid=1 during that cycle only.
REQ-017 DONE exit: continuous=1 -> SETTLE with select=00, counter=0; continuous=0 -> IDLE with select=00.
REQ-018 Latency: vec_valid SHALL be high in the cycle 4*DWELL+1 clocks after the edge sampling start (17 for DWELL=4).
REQ-019 start while busy=1 SHALL be ignored (no restart, no queuing).
REQ-020 sample_vec SHALL hold its value between DONE cycles; partial scans never appear on sample_vec.
REQ-021 continuous sampled only in DONE; a change mid-scan affects only the next DONE exit.
REQ-022 Dwell counter width SHALL be $clog2(DWELL); wraps never occur (cleared on channel advance).

Reset
REQ-023 rst=1 at a rising edge SHALL force state=IDLE, select=00, counter=0, shadow=0000, sample_vec=0000, vec_valid=0, busy=0.
REQ-024 Reset mid-scan SHALL discard the partial shadow vector; no vec_valid is produced for the aborted scan.
REQ-025 rst has priority over start and continuous in the same cycle.

Structure
REQ-026 Shared package SHALL hold the state enum (IDLE, SETTLE, SAMPLE, DONE), default DWELL constant and channel-count constant (4).
REQ-027 One sub-module, dwell_counter (clear, enable, terminal-count output), SHALL implement the per-channel counter.
REQ-028 Top level SHALL contain only FSM, select register, shadow/output registers and the dwell_counter instance.

Verification
REQ-029 DWELL=4, mux tied to model with inputs a..d=1,0,1,1, start pulse, continuous=0 -> vec_valid at cycle 17, sample_vec=1101, then IDLE, busy=0.
REQ-030 Same setup, trace select -> 00 for 4 cycles, 01 for 4, 10 for 4, 11 for 4, then 00; no glitch values.
REQ-031 continuous=1, inputs changed from 0101 to 1010 during first scan's DONE -> vec_valid every 17 cycles, vectors 0101 then 1010.
REQ-032 start pulsed again at cycle 6 of a scan -> ignored; single vec_valid at cycle 17.
REQ-033 rst asserted at cycle 9 of a scan -> next cycle select=00, busy=0, sample_vec=0000, no vec_valid; new start completes normally.
REQ-034 DWELL=2 -> each channel held 2 cycles, vec_valid 9 cycles after start.
